// File: rtl/bcd_display_pkg.sv
// Shared constants for the multiplexed BCD display: active-low segment glyphs
// and output polarities used by the decoder and the scan datapath.
package bcd_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;
  localparam logic DP_LIT  = 1'b0;
  localparam logic DP_DARK = 1'b1;

  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam seg7_t SEG_0    = 7'b1000000;
  localparam seg7_t SEG_1    = 7'b1111001;
  localparam seg7_t SEG_2    = 7'b0100100;
  localparam seg7_t SEG_3    = 7'b0110000;
  localparam seg7_t SEG_4    = 7'b0011001;
  localparam seg7_t SEG_5    = 7'b0010010;
  localparam seg7_t SEG_6    = 7'b0000010;
  localparam seg7_t SEG_7    = 7'b1111000;
  localparam seg7_t SEG_8    = 7'b0000000;
  localparam seg7_t SEG_9    = 7'b0010000;
  localparam seg7_t SEG_DASH = 7'b0111111;
  localparam seg7_t SEG_OFF  = 7'b1111111;

  function automatic logic nibble_is_zero(input logic [3:0] v);
    return (v == 4'd0);
  endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Snapshot/control inputs and display pin outputs of the BCD scan driver.
interface bcd_display_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic                blank_lz;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;

  modport master (
    output digits_in, load, dp_in, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  digits_in, load, dp_in, blank_lz,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment glyph; codes 10-15 show a dash.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] value_i,
  output seg7_t      seg_o
);

  // Glyph lookup
  always_comb begin
    seg_o = SEG_DASH;
    case (value_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Snapshots a packed BCD value and time-multiplexes it onto a common-anode
// display with leading-zero blanking, decimal points and a blank cycle per slot.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_scan_if.slave  bus
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  seg7_t               seg_q, seg_d;
  logic                dp_q, dp_d;

  logic [3:0] cur_digit_s;
  logic       cur_dp_s;
  seg7_t      dec_seg_s;
  logic       zero_run_s;
  logic       blank_s;

  // Prescaler and scan index advance
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = PRE_ZERO;
      if (idx_q == IDX_LAST) begin
        idx_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
  end

  // Snapshot capture; a held load simply tracks the input
  always_comb begin
    if (bus.load) begin
      snap_digits_d = bus.digits_in;
      snap_dp_d     = bus.dp_in;
    end else begin
      snap_digits_d = snap_digits_q;
      snap_dp_d     = snap_dp_q;
    end
  end

  assign cur_digit_s = snap_digits_q[{idx_q, 2'b00} +: 4];
  assign cur_dp_s    = snap_dp_q[idx_q];

  bcd_to_seg7 u_dec (
    .value_i (cur_digit_s),
    .seg_o   (dec_seg_s)
  );

  // Leading-zero blank: walk down from the top digit keeping a run-of-zeros flag
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = 1'b0;
    for (int j = DIGITS - 1; j >= 1; j--) begin
      zero_run_s = zero_run_s & nibble_is_zero(snap_digits_q[4*j +: 4]);
      if (IDX_W'(j) == idx_q) begin
        blank_s = bus.blank_lz & zero_run_s;
      end else begin
        blank_s = blank_s;
      end
    end
  end

  // Next output values; the anode is dark for the first cycle of each slot
  always_comb begin
    if (pre_q == PRE_ZERO) begin
      an_d = {DIGITS{AN_OFF}};
    end else begin
      an_d = ~(DIGITS'(1) << idx_q);
    end
    if (blank_s) begin
      seg_d = SEG_OFF;
      dp_d  = DP_DARK;
    end else begin
      seg_d = dec_seg_s;
      dp_d  = cur_dp_s ? DP_LIT : DP_DARK;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q         <= PRE_ZERO;
      idx_q         <= IDX_ZERO;
      snap_digits_q <= {(4*DIGITS){1'b0}};
      snap_dp_q     <= {DIGITS{1'b0}};
      an_q          <= {DIGITS{AN_OFF}};
      seg_q         <= SEG_OFF;
      dp_q          <= DP_DARK;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboarded bench for bcd_display_scan: an arithmetic frame model predicts
// every output cycle, plus directed checks of glyphs, latency and reset.
module tb_bcd_display_scan;

  localparam int D = 4;
  localparam int R = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  bcd_display_scan_if #(.DIGITS(D)) dut_if ();

  bcd_display_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  obs_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_cyc = 0;
  int unsigned m_val = 0;
  int unsigned m_dpv = 0;

  function automatic logic [6:0] glyph(input int unsigned v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: slot = (cycle / R) mod D, phase = cycle mod R since reset
  initial begin : model
    int   slot;
    int   phase;
    bit   blank;
    obs_t e;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_cyc = 0;
        m_val = 0;
        m_dpv = 0;
      end else begin
        slot  = int'((m_cyc / R) % D);
        phase = int'(m_cyc % R);
        blank = (dut_if.blank_lz === 1'b1) && (slot >= 1) && ((m_val >> (4 * slot)) == 0);
        e.an  = (phase == 0) ? 4'b1111 : 4'(~(1 << slot));
        e.seg = blank ? 7'h7F : glyph((m_val >> (4 * slot)) & 15);
        e.dp  = blank ? 1'b1 : !((m_dpv >> slot) & 1);
        exp_q.push_back(e);
        if (dut_if.load === 1'b1) begin
          m_val = 32'(dut_if.digits_in);
          m_dpv = 32'(dut_if.dp_in);
        end
        m_cyc++;
      end
    end
  end

  // Monitor: every output cycle is compared against the oldest prediction
  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {dut_if.an, dut_if.seg, dut_if.dp};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   $time, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
    dut_if.digits_in = v;
    dut_if.dp_in     = dpv;
    dut_if.load      = 1'b1;
    @(negedge clk);
    dut_if.load      = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_slot(input string name, input logic [3:0] an_pat,
                             input logic [6:0] seg_want, input logic dp_want);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (dut_if.an === an_pat) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s: anode %b not seen within 40 cycles", name, an_pat);
    end else if (dut_if.seg !== seg_want || dut_if.dp !== dp_want) begin
      n_bad++;
      $display("FAIL %s: got seg=%b dp=%b want seg=%b dp=%b",
               name, dut_if.seg, dut_if.dp, seg_want, dp_want);
    end
  endtask

  // Returns at the negedge showing the first lit cycle of the digit-0 slot
  task automatic find_d0_lit(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (dut_if.an === 4'b1111) begin
        @(negedge clk);
        if (dut_if.an === 4'b1110) found = 1'b1;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s: digit-0 slot start not seen within budget", name);
    end
  endtask

  initial begin : stimulus
    reset            = 1'b1;
    dut_if.digits_in = 16'h0000;
    dut_if.dp_in     = 4'b0000;
    dut_if.load      = 1'b0;
    dut_if.blank_lz  = 1'b0;
    tick(3);
    check("reset_an",  12'(dut_if.an),  12'h00F);
    check("reset_seg", 12'(dut_if.seg), 12'h07F);
    check("reset_dp",  12'(dut_if.dp),  12'h001);
    reset = 1'b0;
    tick(16);
    expect_slot("zero_d3", 4'b0111, 7'b1000000, 1'b1);

    do_load(16'h1234, 4'b0100);
    expect_slot("1234_d0", 4'b1110, 7'b0011001, 1'b1);
    expect_slot("1234_d1", 4'b1101, 7'b0110000, 1'b1);
    expect_slot("1234_d2", 4'b1011, 7'b0100100, 1'b0);
    expect_slot("1234_d3", 4'b0111, 7'b1111001, 1'b1);

    dut_if.blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    expect_slot("lz_d0", 4'b1110, 7'b1000000, 1'b1);
    expect_slot("lz_d1", 4'b1101, 7'b1111000, 1'b1);
    expect_slot("lz_d2", 4'b1011, 7'h7F,      1'b1);
    expect_slot("lz_d3", 4'b0111, 7'h7F,      1'b1);
    dut_if.blank_lz = 1'b0;
    expect_slot("nolz_d2", 4'b1011, 7'b1000000, 1'b1);
    expect_slot("nolz_d3", 4'b0111, 7'b1000000, 1'b1);

    dut_if.blank_lz = 1'b1;
    do_load(16'hA00F, 4'b0000);
    expect_slot("inv_d0", 4'b1110, 7'b0111111, 1'b1);
    expect_slot("inv_d1", 4'b1101, 7'b1000000, 1'b1);
    expect_slot("inv_d3", 4'b0111, 7'b0111111, 1'b1);

    dut_if.blank_lz = 1'b0;
    do_load(16'h0000, 4'b0000);
    find_d0_lit("lat_align");
    dut_if.digits_in = 16'h0009;
    dut_if.load      = 1'b1;
    @(negedge clk);
    dut_if.load      = 1'b0;
    check("lat_n1", 12'(dut_if.seg), 12'(7'b1000000));
    @(negedge clk);
    check("lat_n2", 12'(dut_if.seg), 12'(7'b0010000));

    find_d0_lit("edge_align");
    @(negedge clk);
    dut_if.digits_in = 16'h0050;
    dut_if.load      = 1'b1;
    @(negedge clk);
    dut_if.load      = 1'b0;
    @(negedge clk);
    check("edge_blank_an", 12'(dut_if.an), 12'(4'b1111));
    @(negedge clk);
    check("edge_d1_an",  12'(dut_if.an),  12'(4'b1101));
    check("edge_d1_seg", 12'(dut_if.seg), 12'(7'b0010010));

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      dut_if.digits_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dut_if.dp_in     = 4'($urandom);
      dut_if.load      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) dut_if.blank_lz = ~dut_if.blank_lz;
    end
    @(negedge clk);
    dut_if.load = 1'b0;

    do_load(16'h1234, 4'b0000);
    expect_slot("pre_reset_d2", 4'b1011, 7'b0100100, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midreset_an",  12'(dut_if.an),  12'h00F);
    check("midreset_seg", 12'(dut_if.seg), 12'h07F);
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_blank", 12'(dut_if.an), 12'(4'b1111));
    @(negedge clk);
    check("post_reset_first", 12'(dut_if.an), 12'(4'b1110));
    check("post_reset_seg",   12'(dut_if.seg), 12'(7'b1000000));
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed 7-segment driver that consumes the digit/carry chain of the reaction timer's BCD counters. On a `load` strobe it snapshots a packed multi-digit BCD value. It then time-multiplexes the snapshot onto a common-anode display, one digit per refresh slot, with optional leading-zero blanking, per-digit decimal points and a one-cycle anti-ghosting blank at every digit change. It sits directly downstream of the cascaded counters and drives the board display pins.

## Interface
- `DIGITS`, 4: number of BCD digits and anodes (≥2).
- `REFRESH_DIV`, 50000: clk cycles per digit slot (≥2).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `digits_in`  in  4*DIGITS  packed BCD; digit i = bits [4i+3:4i]; digit 0 is least significant.
- `load`  in  1  single-cycle strobe; captures `digits_in` and `dp_in` into the snapshot.
- `dp_in`  in  DIGITS  decimal-point request per digit, 1 = lit; captured with `load`.
- `blank_lz`  in  1  leading-zero blanking enable; level, sampled live, not captured.
- `an`  out  DIGITS  anode enables, active-low, one-hot-low or all-high.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Snapshot registers `snap_d[4*DIGITS]` and `snap_dp[DIGITS]` load when `load`=1; otherwise hold. The display never shows `digits_in` directly.
- Prescaler `pre` counts 0..REFRESH_DIV-1 and wraps. When `pre`=REFRESH_DIV-1, scan index `idx` advances, wrapping DIGITS-1 → 0.
- Decode of digit value v:
  - 0–9: standard patterns.
  - 10–15: invalid; shows '-' (only g lit, `seg`=7'b0111111).
- Leading-zero blank: digit i (i≥1) is blank when `blank_lz`=1 and snap digits i..DIGITS-1 are all 0. Digit 0 is never blanked, so a value of 0 shows "0".
- A blanked digit drives `seg`=7'h7F and `dp`=1. Its anode still follows the scan.
- `dp` = ~`snap_dp[idx]` for unblanked digits.
- All three outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset values: `an`=all 1s, `seg`=7'h7F, `dp`=1, `pre`=0, `idx`=0, snapshot=0. Reset mid-scan returns to these values immediately (asynchronous). The first lit slot after release is digit 0.
- Register equations, from state at cycle t to outputs at t+1:
  - `an` = all 1s if `pre`(t)=0, else ~(1<<`idx`(t)).
  - `seg`/`dp` = decode of `snap`(t)[`idx`(t)].
- Each slot is REFRESH_DIV cycles: one blank cycle, then REFRESH_DIV-1 lit cycles. The full frame is DIGITS×REFRESH_DIV cycles.
- Load latency: `load` at cycle N → snapshot updated at N+1 → outputs reflect it from N+2 if the current slot is lit.
- `load` coincident with `idx` advance: both take effect; the new slot decodes the new snapshot.
- `load` held high for several cycles: the snapshot tracks `digits_in` every cycle. This is legal.
- A `blank_lz` change is visible on the next registered output.

## Structure
- Shared package `bcd_display_pkg`:
  - Segment pattern constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`.
  - Active-low polarity constants.
- Sub-module `bcd_to_seg7`: purely combinational, 4-bit value in, 7-bit active-low pattern out. Instantiated once in the scan datapath.
- The top module holds the prescaler, index, snapshot, blanking logic and output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset, then run 16 cycles with no `load` → `an` cycles through 1111,1110×3, 1111,1101×3, …; `seg`=7'b1000000 ("0") on digit 0; digits 1–3 show "0" with `blank_lz`=0.
- `load` of 16'h1234, `dp_in`=4'b0100, `blank_lz`=0 → over one frame:
  - digit0 `seg`=7'b0011001 ("4")
  - digit1 `seg`=7'b0110000 ("3")
  - digit2 `seg`=7'b0100100 ("2") with `dp`=0
  - digit3 `seg`=7'b1111001 ("1")
- `load` of 16'h0070, `blank_lz`=1 → digits 2 and 3 show `seg`=7'h7F, digit1 shows "7" (7'b1111000), digit0 shows "0". With `blank_lz`=0, digits 2 and 3 show "0".
- `load` of 16'hA00F → digit0 and digit3 show `seg`=7'b0111111 ('-'); digit 3 is not blanked even with `blank_lz`=1.
- `load` pulse at cycle N during a lit digit-0 slot with 16'h0009 → `seg` changes at N+2, not N+1.
- `load` coincident with `pre`=3 → the next slot decodes the new value.
- Assert `reset` mid-slot on digit 2 → `an`=1111, `seg`=7'h7F the same cycle. After release, the first lit anode is 1110.
